// File: rtl/sram_arbiter_pkg.sv
// Shared constants and types for the two-master SRAM arbiter.
package sram_arbiter_pkg;

  // Datapath widths shared with the rest of the core.
  localparam int unsigned ADDRESS_LEN       = 32;
  localparam int unsigned REGISTER_FILE_LEN = 32;

  // Watchdog counter width; bounds the usable TIMEOUT range to 1..15.
  localparam int unsigned WdW = 4;

  // Master indices as carried on the grant output.
  localparam logic MASTER0 = 1'b0;
  localparam logic MASTER1 = 1'b1;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbIssue = 2'd1,
    ArbBusy  = 2'd2,
    ArbDone  = 2'd3
  } arb_state_e;

  // True on the cycle whose increment would bring the watchdog count up to the limit.
  function automatic logic wd_expired(input logic [WdW-1:0] cnt, input int unsigned limit);
    return (32'(cnt) + 32'd1) == limit;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_grant2.sv
// Two-requester round-robin picker: a lone requester wins, a tie goes to the
// master that was not served last.
module sram_arbiter_rr_grant2
  import sram_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o
);

  // Pure combinational pick; the caller only samples it when some request is up.
  always_comb begin
    grant_o = last_grant_i;
    case (req_i)
      2'b01:   grant_o = MASTER0;
      2'b10:   grant_o = MASTER1;
      2'b11:   grant_o = ~last_grant_i;
      default: grant_o = last_grant_i;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller between two masters. Requests are level-held;
// the winner's op/addr/wdata are latched at grant, the controller's ready
// handshake is tracked to completion, and a watchdog aborts hung accesses.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDRESS_LEN,
  parameter int unsigned DATA_W  = REGISTER_FILE_LEN,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_rd_en,
  input  logic              m0_wr_en,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_done,
  output logic              m0_stall,

  input  logic              m1_rd_en,
  input  logic              m1_wr_en,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_done,
  output logic              m1_stall,

  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,

  output logic              err,
  output logic              grant
);

  arb_state_e state_q, state_d;

  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              op_rd_q, op_rd_d;
  logic              timeout_q, timeout_d;
  logic [WdW-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic              req0, req1;
  logic              pick;
  logic              wd_hit;
  logic              in_done;
  logic              load_rdata;
  logic [DATA_W-1:0] load_val;

  // A request with both rd and wr set is served as a read.
  assign req0   = m0_rd_en | m0_wr_en;
  assign req1   = m1_rd_en | m1_wr_en;
  assign wd_hit = wd_expired(cnt_q, TIMEOUT);

  sram_arbiter_rr_grant2 u_rr_grant2 (
    .req_i        ({req1, req0}),
    .last_grant_i (last_grant_q),
    .grant_o      (pick)
  );

  // Next-state logic: arbitration, issue handshake, completion and watchdog.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_rd_d      = op_rd_q;
    timeout_d    = timeout_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    load_rdata   = 1'b0;
    load_val     = '0;

    unique case (state_q)
      ArbIdle: begin
        // Hold off while the controller is still finishing earlier work.
        if ((req0 | req1) && mem_ready) begin
          grant_d   = pick;
          op_rd_d   = pick ? m1_rd_en : m0_rd_en;
          addr_d    = pick ? m1_addr  : m0_addr;
          wdata_d   = pick ? m1_wdata : m0_wdata;
          cnt_d     = '0;
          timeout_d = 1'b0;
          state_d   = ArbIssue;
        end
      end
      ArbIssue: begin
        cnt_d = cnt_q + 4'd1;
        if (wd_hit) begin
          timeout_d  = 1'b1;
          load_rdata = 1'b1;
          state_d    = ArbDone;
        end else if (!mem_ready) begin
          // Controller went busy: it has taken the command.
          state_d = ArbBusy;
        end
      end
      ArbBusy: begin
        cnt_d = cnt_q + 4'd1;
        if (mem_ready) begin
          // Real completion beats a watchdog expiring on the same cycle.
          load_rdata = 1'b1;
          load_val   = op_rd_q ? mem_rdata : '0;
          state_d    = ArbDone;
        end else if (wd_hit) begin
          timeout_d  = 1'b1;
          load_rdata = 1'b1;
          state_d    = ArbDone;
        end
      end
      ArbDone: begin
        last_grant_d = grant_q;
        state_d      = ArbIdle;
      end
      default: state_d = ArbIdle;
    endcase
  end

  // Only the served master's read-data register changes; the other one holds.
  always_comb begin
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    if (load_rdata) begin
      if (grant_q == MASTER1) begin
        m1_rdata_d = load_val;
      end else begin
        m0_rdata_d = load_val;
      end
    end
  end

  // State and datapath registers. last_grant resets to master 1 so master 0
  // wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ArbIdle;
      grant_q      <= MASTER0;
      last_grant_q <= MASTER1;
      op_rd_q      <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_rd_q      <= op_rd_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    in_done   = (state_q == ArbDone);
    mem_rd_en = (state_q == ArbIssue) &  op_rd_q;
    mem_wr_en = (state_q == ArbIssue) & ~op_rd_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    m0_done   = in_done & (grant_q == MASTER0);
    m1_done   = in_done & (grant_q == MASTER1);
    m0_stall  = req0 & ~m0_done;
    m1_stall  = req1 & ~m1_done;
    m0_rdata  = m0_rdata_q;
    m1_rdata  = m1_rdata_q;
    err       = in_done & timeout_q;
    grant     = grant_q;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized scoreboard bench for sram_arbiter with a behavioural SRAM
// controller and a transaction-level reference model.
module tb_sram_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          m0_rd_en = 1'b0, m0_wr_en = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic [DW-1:0] m0_rdata;
  logic          m0_done, m0_stall;
  logic          m1_rd_en = 1'b0, m1_wr_en = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic [DW-1:0] m1_rdata;
  logic          m1_done, m1_stall;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready;
  logic          err, grant;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_rd_en  (m0_rd_en),
    .m0_wr_en  (m0_wr_en),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_rdata  (m0_rdata),
    .m0_done   (m0_done),
    .m0_stall  (m0_stall),
    .m1_rd_en  (m1_rd_en),
    .m1_wr_en  (m1_wr_en),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_rdata  (m1_rdata),
    .m1_done   (m1_done),
    .m1_stall  (m1_stall),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .err       (err),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SRAM controller model ----------------
  bit          force_busy = 1'b0;  // ready held low while idle
  bit          stuck_high = 1'b0;  // never accepts, ready stays high
  bit          stuck_low  = 1'b0;  // accepts, then never finishes
  int          busy_cnt;
  logic [31:0] ctl_rdata;
  logic [31:0] ctl_mem [256];

  function automatic logic [31:0] def_word(input int idx);
    if (idx == 64) return 32'hDEADBEEF;  // address 0x100
    return (32'(idx) * 32'h9E3779B9) ^ 32'h0F0F0F0F;
  endfunction

  assign mem_rdata = ctl_rdata;
  assign mem_ready = stuck_high ? 1'b1
                   : (busy_cnt == 0) && !mem_rd_en && !mem_wr_en && !force_busy;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cnt  <= 0;
      ctl_rdata <= '0;
      for (int i = 0; i < 256; i++) ctl_mem[i] <= def_word(i);
    end else if ((mem_rd_en || mem_wr_en) && !stuck_high && busy_cnt == 0) begin
      busy_cnt <= 5;
      if (mem_rd_en) ctl_rdata <= ctl_mem[mem_addr[9:2]];
      else           ctl_mem[mem_addr[9:2]] <= mem_wdata;
    end else if (busy_cnt != 0 && !stuck_low) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // ---------------- Reference model and scoreboard ----------------
  typedef struct {
    bit          m;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          lat;
    int          en;
    int          start;
  } item_t;

  item_t       exp_q[$];
  logic [31:0] ref_mem [256];
  bit          model_last = 1'b1;
  logic [31:0] last_rdata [2];
  int          hold_cnt [2];
  int          en_cycles = 0;
  int          checks = 0;
  int          errors = 0;
  item_t       mon_it;
  bit          gm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = def_word(i);
    model_last    = 1'b1;
    last_rdata[0] = '0;
    last_rdata[1] = '0;
    exp_q.delete();
    en_cycles     = 0;
  endtask

  // Expected outcome of one transaction in service order.
  task automatic push_txn(input bit m, input bit rd, input logic [31:0] a,
                          input logic [31:0] w, input int lat, input int en, input bit e);
    item_t it;
    it.m = m; it.rd = rd; it.addr = a; it.wdata = w;
    it.lat = lat; it.en = en; it.err = e; it.start = cyc;
    if (e) begin
      it.rdata = '0;
    end else if (rd) begin
      it.rdata = ref_mem[a[9:2]];
    end else begin
      it.rdata = '0;
      ref_mem[a[9:2]] = w;
    end
    exp_q.push_back(it);
    model_last = m;
  endtask

  task automatic drive(input bit m, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] w);
    if (m) begin m1_rd_en = rd; m1_wr_en = wr; m1_addr = a; m1_wdata = w; end
    else   begin m0_rd_en = rd; m0_wr_en = wr; m0_addr = a; m0_wdata = w; end
    hold_cnt[m] = 1;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    if (exp_q.size() != 0) begin
      exp_q.delete();
      m0_rd_en = 1'b0; m0_wr_en = 1'b0; m1_rd_en = 1'b0; m1_wr_en = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_rd_en"}, mem_rd_en, 0);
    check({tag, "_mem_wr_en"}, mem_wr_en, 0);
    check({tag, "_mem_addr"},  mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_m0_rdata"},  m0_rdata, 0);
    check({tag, "_m1_rdata"},  m1_rdata, 0);
    check({tag, "_m0_done"},   m0_done, 0);
    check({tag, "_m1_done"},   m1_done, 0);
    check({tag, "_m0_stall"},  m0_stall, 0);
    check({tag, "_m1_stall"},  m1_stall, 0);
    check({tag, "_err"},       err, 0);
    check({tag, "_grant"},     grant, 0);
  endtask

  // Monitor: per-cycle protocol checks, and a scoreboard pop on every done.
  always @(negedge clk) begin
    if (rst) begin
      check("m0_stall", m0_stall, (m0_rd_en | m0_wr_en) & ~m0_done);
      check("m1_stall", m1_stall, (m1_rd_en | m1_wr_en) & ~m1_done);
      if (force_busy) check("no_issue_while_ctl_busy", mem_rd_en | mem_wr_en, 0);
      if (mem_rd_en || mem_wr_en) begin
        en_cycles++;
        check("single_enable", mem_rd_en & mem_wr_en, 0);
        if (exp_q.size() == 0) begin
          check("enable_without_txn", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_it = exp_q[0];
          check("mem_op_is_read", mem_rd_en, mon_it.rd);
          check("mem_addr", mem_addr, mon_it.addr);
          if (!mon_it.rd) check("mem_wdata", mem_wdata, mon_it.wdata);
        end
      end
      check("done_exclusive", m0_done & m1_done, 0);
      if (m0_done || m1_done) begin
        gm = m1_done;
        if (exp_q.size() == 0) begin
          check("done_without_txn", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_it = exp_q.pop_front();
          check("done_master", gm, mon_it.m);
          check("grant", grant, mon_it.m);
          check("rdata", gm ? m1_rdata : m0_rdata, mon_it.rdata);
          check("rdata_other_hold", gm ? m0_rdata : m1_rdata, last_rdata[!gm]);
          check("err", err, mon_it.err);
          check("latency", 32'(cyc - mon_it.start), 32'(mon_it.lat));
          check("enable_cycles", 32'(en_cycles), 32'(mon_it.en));
          last_rdata[gm] = mon_it.rdata;
        end
        en_cycles = 0;
        hold_cnt[gm]--;
        if (hold_cnt[gm] <= 0) begin
          if (gm) begin m1_rd_en = 1'b0; m1_wr_en = 1'b0; end
          else    begin m0_rd_en = 1'b0; m0_wr_en = 1'b0; end
        end
      end else begin
        check("err_without_done", err, 0);
      end
    end
  end

  // One random round: one or both masters issue at once.
  task automatic rand_round();
    bit [1:0]    sel;
    bit          first;
    bit          rdf [2];
    bit          wrf [2];
    logic [31:0] a [2];
    logic [31:0] w [2];
    int          kind;
    sel = 2'($urandom_range(1, 3));
    for (int m = 0; m < 2; m++) begin
      kind   = $urandom_range(0, 2);  // 0 read, 1 write, 2 both (served as read)
      rdf[m] = (kind != 1);
      wrf[m] = (kind != 0);
      a[m]   = 32'h100 + 32'(4 * $urandom_range(0, 3));
      w[m]   = $urandom;
    end
    first = (sel == 2'b11) ? ~model_last : sel[1];
    push_txn(first, rdf[first], a[first], w[first], 8, 1, 1'b0);
    if (sel == 2'b11) push_txn(~first, rdf[~first], a[~first], w[~first], 17, 1, 1'b0);
    if (sel[0]) drive(1'b0, rdf[0], wrf[0], a[0], w[0]);
    if (sel[1]) drive(1'b1, rdf[1], wrf[1], a[1], w[1]);
    // Input changes after grant must not reach the controller.
    repeat (3) @(posedge clk);
    #1;
    if (first) begin m1_addr = $urandom; m1_wdata = $urandom; end
    else       begin m0_addr = $urandom; m0_wdata = $urandom; end
    wait_idle(60);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    hold_cnt[0] = 0;
    hold_cnt[1] = 0;
    model_reset();
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Contention from reset with both held: 0,1,0,1.
    push_txn(1'b0, 1'b1, 32'h100, 32'h0, 8, 1, 1'b0);
    push_txn(1'b1, 1'b1, 32'h104, 32'h0, 17, 1, 1'b0);
    push_txn(1'b0, 1'b1, 32'h100, 32'h0, 26, 1, 1'b0);
    push_txn(1'b1, 1'b1, 32'h104, 32'h0, 35, 1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h104, 32'h0);
    hold_cnt[0] = 2;
    hold_cnt[1] = 2;
    wait_idle(80);

    // Single read.
    push_txn(1'b0, 1'b1, 32'h100, 32'h0, 8, 1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    wait_idle(40);

    // Single write.
    push_txn(1'b1, 1'b0, 32'h204, 32'h12345678, 8, 1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'h204, 32'h12345678);
    wait_idle(40);

    // Read back the written word.
    push_txn(1'b0, 1'b1, 32'h204, 32'h0, 8, 1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h204, 32'h0);
    wait_idle(40);

    // Controller busy at request: arbiter waits in idle for 4 cycles.
    force_busy = 1'b1;
    push_txn(1'b0, 1'b1, 32'h108, 32'h0, 12, 1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h108, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    force_busy = 1'b0;
    wait_idle(40);

    // Watchdog: controller never accepts.
    stuck_high = 1'b1;
    push_txn(1'b1, 1'b1, 32'h108, 32'h0, 16, 15, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 32'h108, 32'h0);
    wait_idle(40);
    stuck_high = 1'b0;

    // Watchdog: controller accepts and never finishes.
    stuck_low = 1'b1;
    push_txn(1'b0, 1'b1, 32'h10C, 32'h0, 16, 1, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 32'h10C, 32'h0);
    wait_idle(40);
    stuck_low = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    for (int r = 0; r < 30; r++) rand_round();

    // Async reset in the middle of a busy read.
    push_txn(1'b0, 1'b1, 32'h104, 32'h0, 8, 1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h104, 32'h0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    m0_rd_en = 1'b0; m0_wr_en = 1'b0; m1_rd_en = 1'b0; m1_wr_en = 1'b0;
    hold_cnt[0] = 0;
    hold_cnt[1] = 0;
    model_reset();
    #1;
    check_outputs_zero("async_reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push_txn(1'b1, 1'b1, 32'h100, 32'h0, 8, 1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    wait_idle(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
